// File: rtl/gray_to_rgb_pkg.sv
// Shared defaults and helpers for the gray-to-RGB output stage.
// The image and pixel defaults match the grayscale and sobel stages.
package gray_to_rgb_pkg;

  localparam int DEF_DWIDTH_IN   = 8;
  localparam int DEF_DWIDTH_OUT  = 24;
  localparam int DEF_IMG_WIDTH   = 720;
  localparam int DEF_IMG_HEIGHT  = 540;

  // Occupancy of the 2-entry skid buffer (0, 1 or 2).
  typedef logic [1:0] occ_t;

  // Counter width for a modulo-n counter. A 1-entry dimension still needs one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gray_to_rgb_skid_buf2.sv
// Two-entry FIFO of pixels. It absorbs the one-cycle read latency so that no
// pixel is lost when the downstream FIFO applies back-pressure. The head is the oldest entry.
module skid_buf2
  import gray_to_rgb_pkg::*;
#(
  parameter int W = DEF_DWIDTH_IN
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output occ_t         count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  occ_t         count_q, count_d;

  // Next-state logic. The caller only pops when the buffer is non-empty.
  // The caller only pushes when there is room or a pop is happening at the same time.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (push_i && pop_i) begin
      if (count_q == 2'd1) begin
        e0_d = din_i;
      end else begin
        e0_d = e1_q;
        e1_d = din_i;
      end
    end else if (push_i) begin
      if (count_q == 2'd0) e0_d = din_i;
      else                 e1_d = din_i;
      count_d = count_q + 2'd1;
    end else if (pop_i) begin
      e0_d    = e1_q;
      count_d = count_q - 2'd1;
    end
  end

  // Storage and occupancy. Reset discards any buffered pixels.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= '0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = e0_q;

endmodule

// File: rtl/gray_to_rgb.sv
// Reads luma pixels from an upstream FWFT FIFO and replicates each one to {g,g,g}.
// Pushes the result to the output FIFO and tracks the column and row of each written pixel.
module gray_to_rgb
  import gray_to_rgb_pkg::*;
#(
  parameter int DWIDTH_IN  = DEF_DWIDTH_IN,
  parameter int DWIDTH_OUT = DEF_DWIDTH_OUT,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  fifo_in_rd_en,
  input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  fifo_out_wr_en,
  output logic [DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                  fifo_out_full,
  output logic                  line_done,
  output logic                  frame_done
);

  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  occ_t                 count;
  logic [DWIDTH_IN-1:0] head;
  logic                 wr, rd;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          line_done_q, line_done_d;
  logic          frame_done_q, frame_done_d;

  skid_buf2 #(.W(DWIDTH_IN)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .push_i  (rd),
    .din_i   (fifo_in_dout),
    .pop_i   (wr),
    .count_o (count),
    .head_o  (head)
  );

  // Handshake: write whenever something is buffered and the output has room.
  // Read whenever there is room, including the slot freed by a write in the same cycle.
  // Both are forced low while reset is held.
  always_comb begin
    wr           = reset && (count != 2'd0) && !fifo_out_full;
    rd           = reset && !fifo_in_empty && ((count < 2'd2) || wr);
    fifo_out_din = '0;
    if (reset && (count != 2'd0)) fifo_out_din = {3{head}};
  end

  assign fifo_in_rd_en  = rd;
  assign fifo_out_wr_en = wr;

  // Column/row position of the next written pixel, and the end-of-line/end-of-frame flags.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    if (wr) begin
      if (col_q == LAST_COL) begin
        col_d       = '0;
        line_done_d = 1'b1;
        if (row_q == LAST_ROW) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position counters and registered done pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gray_to_rgb.sv
// Bench for gray_to_rgb on a 4x2 image. A behavioural FWFT source feeds pixels to the DUT.
// A scoreboard of popped pixels is checked by an independent monitor.
module tb_gray_to_rgb;

  localparam int W = 4;
  localparam int H = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fifo_in_rd_en;
  logic [7:0]  fifo_in_dout = '0;
  logic        fifo_in_empty = 1'b1;
  logic        fifo_out_wr_en;
  logic [23:0] fifo_out_din;
  logic        fifo_out_full = 1'b0;
  logic        line_done;
  logic        frame_done;

  gray_to_rgb #(
    .DWIDTH_IN(8), .DWIDTH_OUT(24), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full),
    .line_done      (line_done),
    .frame_done     (frame_done)
  );

  always #5 clock = ~clock;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic       full_v = 1'b0;

  logic        snap_rd, snap_wr;
  logic [23:0] snap_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive();
    fifo_in_empty = (src_q.size() == 0);
    fifo_in_dout  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    fifo_out_full = full_v;
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(8'(first + i));
    drive();
  endtask

  // Sample one cycle at the falling edge, then commit the source pop after the rising edge.
  task automatic step();
    logic rd_n;
    @(negedge clock);
    rd_n     = fifo_in_rd_en;
    snap_rd  = fifo_in_rd_en;
    snap_wr  = fifo_out_wr_en;
    snap_din = fifo_out_din;
    @(posedge clock);
    #1;
    if (rd_n && src_q.size() != 0) exp_q.push_back(src_q.pop_front());
    drive();
  endtask

  task automatic drain(input string name);
    int n = 0;
    full_v = 1'b0;
    drive();
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    step();
    check(name, 32'((src_q.size() == 0) && (exp_q.size() == 0)), 32'd1);
  endtask

  // Monitor: compares each written word against the scoreboard.
  // It also models the line/frame position to predict the done pulses.
  int   m_col = 0, m_row = 0;
  logic exp_ld = 1'b0, exp_fd = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      m_col  = 0;
      m_row  = 0;
      exp_ld = 1'b0;
      exp_fd = 1'b0;
    end else begin
      check("line_done", 32'(line_done), 32'(exp_ld));
      check("frame_done", 32'(frame_done), 32'(exp_fd));
      exp_ld = 1'b0;
      exp_fd = 1'b0;
      if (fifo_out_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(fifo_out_din), 32'hDEAD_BEEF);
        end else begin
          logic [7:0] p;
          p = exp_q.pop_front();
          check("fifo_out_din", 32'(fifo_out_din), 32'({p, p, p}));
        end
        if (m_col == W - 1) begin
          exp_ld = 1'b1;
          m_col  = 0;
          if (m_row == H - 1) begin
            exp_fd = 1'b1;
            m_row  = 0;
          end else begin
            m_row++;
          end
        end else begin
          m_col++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    step();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset: outputs must be zero even with a pixel waiting upstream.
    load(8'hEE, 1);
    #2;
    check("reset_rd_en", 32'(fifo_in_rd_en), 32'd0);
    check("reset_wr_en", 32'(fifo_out_wr_en), 32'd0);
    check("reset_din", 32'(fifo_out_din), 32'd0);
    check("reset_line_done", 32'(line_done), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    src_q.delete();
    drive();
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Single pixel: a read pulse, then one write one cycle later.
    load(8'h5A, 1);
    step();
    check("t1_rd_pulse", 32'(snap_rd), 32'd1);
    check("t1_no_wr_yet", 32'(snap_wr), 32'd0);
    step();
    check("t1_rd_done", 32'(snap_rd), 32'd0);
    check("t1_wr", 32'(snap_wr), 32'd1);
    check("t1_din", 32'(snap_din), 32'h5A5A5A);
    step();
    check("t1_idle", 32'(snap_wr), 32'd0);

    // Back-to-back stream at full throughput.
    do_reset();
    load(8'h00, 16);
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      check("t2_wr_every_cycle", 32'(snap_wr), 32'd1);
      check("t2_din", 32'(snap_din), 32'({3{8'(i)}}));
    end
    step();
    check("t2_idle", 32'(snap_wr), 32'd0);

    // Back-pressure: the buffer fills to two entries and reads stop.
    do_reset();
    load(8'h10, 8);
    step();
    full_v = 1'b1;
    drive();
    step();
    check("t3_second_pop", 32'(snap_rd), 32'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      check("t3_rd_stalled", 32'(snap_rd), 32'd0);
      check("t3_wr_stalled", 32'(snap_wr), 32'd0);
    end
    check("t3_source_left", 32'(src_q.size()), 32'd6);
    drain("t3_drain");

    // Line and frame pulses over nine pixels of a 4x2 image.
    do_reset();
    load(8'h40, 9);
    drain("t4_drain");

    // Both sides stalled with two entries held.
    do_reset();
    full_v = 1'b1;
    load(8'hA0, 2);
    step();
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      check("t5_hold", 32'({snap_rd, snap_wr}), 32'd0);
    end
    drain("t5_drain");

    // Reset mid-line with two pixels buffered. The buffered pixels are discarded.
    do_reset();
    load(8'h60, 5);
    drain("t6_first_five");
    full_v = 1'b1;
    load(8'h70, 2);
    step();
    step();
    step();
    load(8'h80, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_rd_en", 32'(fifo_in_rd_en), 32'd0);
    check("t6_rst_wr_en", 32'(fifo_out_wr_en), 32'd0);
    check("t6_rst_din", 32'(fifo_out_din), 32'd0);
    step();
    @(posedge clock);
    #1;
    reset = 1'b1;
    load(8'h81, 4);
    drain("t6_after_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
